// File: rtl/grant_responder_pkg.sv
// Shared state encoding and default parameter values for the grant_responder block.
package grant_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REVOKE = 2'd2
  } state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/grant_responder_rrpick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping to 0.
module grant_responder_rrpick
  import grant_responder_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int PW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [PW-1:0]    index_o
);

  int          pos;
  logic [PW-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest hit to ptr is written last.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    pos     = 0;
    pos_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos     = (int'(ptr_i) + i) % N_REQ;
      pos_idx = PW'(pos);
      if (req_i[pos_idx]) begin
        valid_o = 1'b1;
        index_o = pos_idx;
      end
    end
  end

endmodule

// File: rtl/grant_responder.sv
// Round-robin single-owner grant FSM; GRANT_RESPONDER_TIMEOUT_EN adds the timeout revoke path.
module grant_responder
  import grant_responder_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_ck,
  input  logic             i_arst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_release,
  output logic [N_REQ-1:0] o_grant,
  output logic [N_REQ-1:0] o_revoke,
  output logic             o_busy
);

  localparam int PW = $clog2(N_REQ);

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] own_mask;
  logic             rel_own;
  logic [PW-1:0]    nxt_ptr;
  logic             pick_vld;
  logic [PW-1:0]    pick_idx;

  grant_responder_rrpick #(
    .N_REQ (N_REQ)
  ) u_rrpick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .index_o (pick_idx)
  );

  assign own_mask = onehot(owner_q);
  assign rel_own  = |(i_release & own_mask);
  assign nxt_ptr  = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef GRANT_RESPONDER_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] revoke_q, revoke_d;
  logic             timeout_hit;

  // Revoke only makes sense when someone else is actually waiting.
  assign timeout_hit = (cnt_q == CNT_MAX) && (|(i_req & ~own_mask));

  always_ff @(posedge i_ck or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q    <= '0;
      revoke_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      revoke_q <= revoke_d;
    end
  end

  assign o_revoke = revoke_q;
`else
  assign o_revoke = '0;
`endif

  always_ff @(posedge i_ck or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // Release is checked before timeout so a tie always returns to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef GRANT_RESPONDER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
`ifdef GRANT_RESPONDER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel_own) begin
          state_d = IDLE;
          ptr_d   = nxt_ptr;
        end
`ifdef GRANT_RESPONDER_TIMEOUT_EN
        else begin
          if (timeout_hit) state_d = REVOKE;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      REVOKE: begin
        if (rel_own) begin
          state_d = IDLE;
          ptr_d   = nxt_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d  = (state_d != IDLE) ? onehot(owner_d) : '0;
`ifdef GRANT_RESPONDER_TIMEOUT_EN
    revoke_d = (state_d == REVOKE) ? onehot(owner_d) : '0;
`endif
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_grant_responder.sv
// Directed bench for grant_responder; timeout expectations follow GRANT_RESPONDER_TIMEOUT_EN.
module tb_grant_responder;

`ifdef GRANT_RESPONDER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic [3:0] o_grant;
  logic [3:0] o_revoke;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  grant_responder #(
    .N_REQ   (4),
    .TIMEOUT (16)
  ) dut (
    .i_ck      (clk),
    .i_arst_n  (rst_n),
    .i_req     (req),
    .i_release (rel),
    .o_grant   (o_grant),
    .o_revoke  (o_revoke),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("onehot_grant", 32'($onehot0(o_grant)), 32'd1);
    chk("onehot_revoke", 32'($onehot0(o_revoke)), 32'd1);
    chk("revoke_implies_grant", 32'((o_revoke & ~o_grant) == 4'b0000), 32'd1);
    chk("busy_vs_grant", 32'(o_busy), 32'(o_grant != 4'b0000));
  end

  initial begin
    #12;
    chk("reset_grant", 32'(o_grant), 32'h0);
    chk("reset_revoke", 32'(o_revoke), 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin from ptr=0 with every port requesting
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_grant", 32'(o_grant), 32'(rr_exp[n]));
      chk("rr_busy", 32'(o_busy), 32'h1);
      step();
      chk("rr_hold", 32'(o_grant), 32'(rr_exp[n]));
      rel = rr_exp[n];
      step();
      rel = '0;
      chk("rr_bubble_grant", 32'(o_grant), 32'h0);
      chk("rr_bubble_busy", 32'(o_busy), 32'h0);
    end
    req = '0;

    // Single requester 3, request dropped, stray release on port 1
    req = 4'b1000;
    step();
    chk("single_grant", 32'(o_grant), 32'h8);
    req = '0;
    step();
    chk("req_drop_hold", 32'(o_grant), 32'h8);
    rel = 4'b0010;
    step();
    rel = '0;
    chk("stray_release", 32'(o_grant), 32'h8);
    step();
    chk("stray_after", 32'(o_grant), 32'h8);
    rel = 4'b1000;
    step();
    rel = '0;
    chk("owner3_release", 32'(o_grant), 32'h0);

    // Latency: request sampled on one edge, grant visible after it
    req = 4'b0100;
    chk("lat_before", 32'(o_grant), 32'h0);
    step();
    chk("lat_grant", 32'(o_grant), 32'h4);
    chk("lat_busy", 32'(o_busy), 32'h1);
    req = '0;
    rel = 4'b0100;
    step();
    rel = '0;
    chk("lat_release", 32'(o_grant), 32'h0);

    // Owner 0 holds while port 2 waits
    req = 4'b0001;
    step();
    chk("to_grant0", 32'(o_grant), 32'h1);
    req = 4'b0101;
    for (int i = 1; i <= 18; i++) begin
      step();
      chk("to_hold_grant", 32'(o_grant), 32'h1);
      chk("to_revoke", 32'(o_revoke), (TO_EN && i >= 16) ? 32'h1 : 32'h0);
    end
    rel = 4'b0001;
    step();
    rel = '0;
    chk("to_release_grant", 32'(o_grant), 32'h0);
    chk("to_release_revoke", 32'(o_revoke), 32'h0);
    step();
    chk("to_next_grant", 32'(o_grant), 32'h4);
    req = '0;
    rel = 4'b0100;
    step();
    rel = '0;
    chk("to_next_release", 32'(o_grant), 32'h0);

    // Release lands on the timeout cycle
    req = 4'b0010;
    step();
    chk("tie_grant", 32'(o_grant), 32'h2);
    req = 4'b0011;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("tie_revoke_low", 32'(o_revoke), 32'h0);
      chk("tie_hold", 32'(o_grant), 32'h2);
    end
    rel = 4'b0010;
    step();
    rel = '0;
    chk("tie_grant_clear", 32'(o_grant), 32'h0);
    chk("tie_revoke_clear", 32'(o_revoke), 32'h0);
    chk("tie_busy", 32'(o_busy), 32'h0);

    // Owner 0 reaches revoke (when enabled), then reset mid-operation
    step();
    chk("mr_grant", 32'(o_grant), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("mr_revoke", 32'(o_revoke), (TO_EN && i == 16) ? 32'h1 : 32'h0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_grant", 32'(o_grant), 32'h0);
    chk("mr_async_revoke", 32'(o_revoke), 32'h0);
    chk("mr_async_busy", 32'(o_busy), 32'h0);
    req = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_first_grant", 32'(o_grant), 32'h2);
    req = '0;
    rel = 4'b0010;
    step();
    rel = '0;
    chk("mr_release", 32'(o_grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grant_responder.md
GRANT_RESPONDER -- requirements
Module: grant_responder

Interface
REQ-001 Parameters SHALL be, one per line:
  N_REQ    4    number of requester ports, 2..8
  TIMEOUT  16   grant cycles before revoke is allowed, 2..256
REQ-002 Ports SHALL be, one per line, with the clock and reset first:
  i_ck        input   1       clock, rising edge
  i_arst_n    input   1       reset, asynchronous, active-low
  i_req       input   N_REQ   per-requester request level
  i_release   input   N_REQ   per-requester release pulse
  o_grant     output  N_REQ   one-hot grant, registered
  o_revoke    output  N_REQ   one-hot revoke notice, registered
  o_busy      output  1       high while any grant is outstanding
REQ-003 The design SHALL use one clock, i_ck, and SHALL use an asynchronous, active-low reset, i_arst_n.

Function
REQ-004 The FSM SHALL have three states: IDLE, GRANT and REVOKE.
REQ-005 In IDLE with i_req != 0, the block SHALL pick an owner by round-robin, starting the search at index ptr and wrapping at N_REQ-1 -> 0.
REQ-006 On that same edge, the block SHALL enter GRANT and set o_grant[owner]=1, so the grant appears 1 cycle after the request is sampled.
REQ-007 In GRANT, i_release[owner]=1 SHALL return the FSM to IDLE on the next edge, clear o_grant, and set ptr=(owner+1) mod N_REQ.
REQ-008 In REVOKE, o_grant[owner] and o_revoke[owner] SHALL both stay high until i_release[owner]=1; the next edge SHALL then behave as in REQ-007.
REQ-009 The block SHALL ignore i_release on any non-owner index, and SHALL ignore a request drop by the owner without a release.
REQ-010 There SHALL be exactly one IDLE bubble cycle between consecutive grants; back-to-back grants SHALL NOT occur.
REQ-011 o_busy SHALL equal (state != IDLE).
REQ-012 o_grant and o_revoke SHALL be one-hot or zero at all times.
REQ-013 o_revoke SHALL be zero outside REVOKE.
REQ-014 The hold counter SHALL be $clog2(TIMEOUT) bits wide and SHALL clear to 0 on entry to GRANT.
REQ-015 The hold counter SHALL increment once per GRANT cycle and SHALL saturate at TIMEOUT-1.
REQ-016 A simultaneous timeout condition and i_release[owner] SHALL be resolved in favour of the release: the FSM goes to IDLE, not REVOKE.
REQ-017 With N_REQ=1 requesting, the round-robin pick SHALL return that index regardless of ptr.

Reset
REQ-018 Asserting i_arst_n=0 SHALL immediately force state=IDLE, ptr=0, counter=0, o_grant=0, o_revoke=0 and o_busy=0, including in the middle of a grant or revoke.
REQ-019 After reset deassertion, the first grant SHALL follow REQ-005 starting from ptr=0.

Configuration
REQ-020 The macro GRANT_RESPONDER_TIMEOUT_EN SHALL control the timeout revoke feature.
REQ-021 With GRANT_RESPONDER_TIMEOUT_EN defined, GRANT SHALL move to REVOKE on the edge where counter==TIMEOUT-1 and (i_req & ~onehot(owner)) != 0.
REQ-022 Without GRANT_RESPONDER_TIMEOUT_EN, the counter SHALL be absent, the REVOKE state SHALL be unreachable, o_revoke SHALL be tied to 0, and a grant SHALL be held until release.

Structure
REQ-023 A shared package grant_responder_pkg SHALL hold the state enum typedef (2-bit, values IDLE/GRANT/REVOKE) and the default parameter constants.
REQ-024 The round-robin search SHALL live in one combinational sub-module, grant_responder_rrpick, with inputs (req, ptr) and outputs (valid, index).
REQ-025 The FSM, ptr, counter and output registers SHALL stay in grant_responder.

Verification
REQ-026 Round-robin: i_req=4'b1111 with each owner releasing 2 cycles after grant -> grants SHALL follow the order 0,1,2,3,0, with one IDLE cycle between each.
REQ-027 Latency: from IDLE, i_req=4'b0100 at edge k -> o_grant=4'b0100 and o_busy=1 after edge k+1.
REQ-028 Timeout (GRANT_RESPONDER_TIMEOUT_EN defined, TIMEOUT=16): owner 0 holds, i_req[2]=1 -> o_revoke=4'b0001 SHALL appear 16 cycles after the grant.
REQ-029 Timeout check continued: the owner releases 3 cycles after revoke -> the next grant SHALL be 4'b0100.
REQ-030 Release/timeout tie: i_release[owner] on the timeout cycle -> the FSM SHALL go to IDLE and o_revoke SHALL never assert.
REQ-031 Mid-operation reset: i_arst_n low during REVOKE -> all outputs SHALL be 0 asynchronously, and the next grant after deassertion SHALL go to the lowest requesting index.
REQ-032 Stray release: i_release=4'b0010 while owner=3 -> the grant SHALL be unchanged; the bench SHALL also assert one-hot on o_grant and o_revoke every cycle.
